imem_loader: RTL and testbench

Program loader that receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into the instruction memory's write port. It holds the CPU's PC enable low during the download. This block is the writer side of the instruction memory, which the single-cycle CPU only reads. It sits between the board-level byte source (switch/UART front end) and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_word_assembler.sv | 54 +++++
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
//            Holds the loader FSM state encoding, stream framing constants
//            and the word-index to byte-address helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam int HEADER_BYTES   = 2;
  localparam int BYTES_PER_WORD = 4;

  // Byte address of word number idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Purpose  : Big-endian word builder. Each accepted byte is shifted in at the
//            LSB end, so the first byte of a word ends up in bits [31:24].
// Ports    : clk, reset     - clock, async active-high reset
//            shift_en       - shift i_byte into the buffer, bump byte counter
//            clear          - zero the buffer and byte counter
//            i_byte         - incoming stream byte
//            o_word         - current buffer contents
//            o_next_word    - buffer value after shifting in i_byte
//            word_full      - the next shift completes a word
// Revision : 1.0 - initial release
// ============================================================================
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [31:0] o_next_word,
  output logic        word_full
);

  logic [31:0] r_buf;
  logic [1:0]  r_cnt;
  logic [31:0] w_next;

  assign w_next = {r_buf[23:0], i_byte};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf <= 32'h0;
      r_cnt <= 2'd0;
    end else if (clear) begin
      r_buf <= 32'h0;
      r_cnt <= 2'd0;
    end else if (shift_en) begin
      r_buf <= w_next;
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Asserted while the counter sits on the last byte slot, so the loader can
  // launch the write on the same edge that accepts the final byte.
  assign word_full   = (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word      = r_buf;
  assign o_next_word = w_next;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Receives a length-prefixed byte stream over valid/ready, packs
//            big-endian 32-bit words and writes them sequentially into the
//            instruction memory, holding the CPU while it does so.
// Ports    : clk, reset              - clock, async active-high reset
//            start                   - begin a download (IDLE/DONE/ERROR only)
//            byte_valid, byte_data   - byte source
//            byte_ready              - loader will take a byte this cycle
//            MemWrite, address,
//            write_data              - instruction memory write port
//            cpu_hold                - keeps the CPU PC disabled
//            busy, done, error       - status
//            word_count              - words written in this download
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [31:0] c_MAX_WORDS = 32'(MAX_WORDS);

  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_word_count;
  logic [31:0] r_address;
  logic [31:0] r_write_data;
  logic        r_mem_write;
  logic        r_byte_ready;
  logic        r_cpu_hold;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_xfer;
  logic        w_start_ok;
  logic [15:0] w_len;
  logic        w_len_over;
  logic        w_shift_en;
  logic        w_asm_clear;
  logic        w_word_full;
  logic [31:0] w_word;
  logic [31:0] w_next_word;

  assign w_xfer     = byte_valid && r_byte_ready;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE) ||
                                (r_state == ERROR));
  // Full length as seen while the low header byte is on the bus.
  assign w_len      = {r_len[15:8], byte_data};
  assign w_len_over = ({16'h0, w_len} > c_MAX_WORDS);

  assign w_shift_en  = (r_state == DATA) && w_xfer;
  assign w_asm_clear = (r_state == WRITE) || w_start_ok;

  word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .shift_en    (w_shift_en),
    .clear       (w_asm_clear),
    .i_byte      (byte_data),
    .o_word      (w_word),
    .o_next_word (w_next_word),
    .word_full   (w_word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_len        <= 16'h0;
      r_word_count <= 16'h0;
      r_address    <= BASE_ADDR;
      r_write_data <= 32'h0;
      r_mem_write  <= 1'b0;
      r_byte_ready <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state      <= LEN_HI;
            r_word_count <= 16'h0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_byte_ready <= 1'b1;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= byte_data;
            r_state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= byte_data;
            if (w_len == 16'h0) begin
              r_state      <= DONE;
              r_byte_ready <= 1'b0;
              r_cpu_hold   <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end else if (w_len_over) begin
              r_state      <= ERROR;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_error      <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          // The write strobe and its address/data are registered on the edge
          // that takes the last byte, so they are valid throughout WRITE.
          if (w_xfer && w_word_full) begin
            r_state      <= WRITE;
            r_byte_ready <= 1'b0;
            r_mem_write  <= 1'b1;
            r_address    <= word_addr(BASE_ADDR, r_word_count);
            r_write_data <= w_next_word;
          end
        end
        WRITE: begin
          r_word_count <= r_word_count + 16'd1;
          if ((r_word_count + 16'd1) == r_len) begin
            r_state      <= DONE;
            r_cpu_hold   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end else begin
            r_state      <= DATA;
            r_byte_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_byte_ready <= 1'b0;
          r_cpu_hold   <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign MemWrite   = r_mem_write;
  assign address    = r_address;
  assign write_data = r_write_data;
  assign cpu_hold   = r_cpu_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

  // The buffer contents are only consumed through o_next_word.
  logic w_unused;
  assign w_unused = ^w_word;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. A cycle table covers the
//            nominal, zero-length and oversize downloads; directed sequences
//            cover stalls, reset mid-word, start during DATA and restart.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        rdy_a, mw_a, hold_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, wd_a;
  logic [15:0] wc_a;
  logic        rdy_b, mw_b, hold_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, wd_b;
  logic [15:0] wc_b;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] wq_a[$];
  logic [63:0] wq_b[$];

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(rdy_a), .MemWrite(mw_a),
    .address(addr_a), .write_data(wd_a), .cpu_hold(hold_a), .busy(busy_a),
    .done(done_a), .error(err_a), .word_count(wc_a)
  );

  imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(256)) dut_b (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(rdy_b), .MemWrite(mw_b),
    .address(addr_b), .write_data(wd_b), .cpu_hold(hold_b), .busy(busy_b),
    .done(done_b), .error(err_b), .word_count(wc_b)
  );

  // Write-port monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (mw_a) wq_a.push_back({addr_a, wd_a});
    if (mw_b) wq_b.push_back({addr_b, wd_b});
  end

  typedef struct {
    logic        st;
    logic        vl;
    logic [7:0]  dat;
    logic        rdy;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        dn;
    logic        er;
    logic        hd;
    logic        bz;
    logic [15:0] wc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic vl, input logic [7:0] dat,
                     input logic rdy, input logic mw, input logic [31:0] addr,
                     input logic [31:0] wd, input logic dn, input logic er,
                     input logic hd, input logic bz, input logic [15:0] wc);
    vec_t v;
    v.st = st; v.vl = vl; v.dat = dat; v.rdy = rdy; v.mw = mw; v.addr = addr;
    v.wd = wd; v.dn = dn; v.er = er; v.hd = hd; v.bz = bz; v.wc = wc;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (rdy_a) got = 1'b1;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    if (!got) check("byte_accept_timeout", 32'(b), 32'hFFFF_FFFF);
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done_a && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 32'(done_a), 32'd1);
  endtask

  int mark;

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    // Nominal two-word load
    add(1,0,8'h00, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h00, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h02, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h20, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h08, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h00, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h05, 0,1,32'h0,32'h2008_0005, 0,0,1,1,16'd0);
    add(0,0,8'h00, 1,0,32'h0,32'h0, 0,0,1,1,16'd1);
    add(0,1,8'h8C, 1,0,32'h0,32'h0, 0,0,1,1,16'd1);
    add(0,1,8'h09, 1,0,32'h0,32'h0, 0,0,1,1,16'd1);
    add(0,1,8'h00, 1,0,32'h0,32'h0, 0,0,1,1,16'd1);
    add(0,1,8'h04, 0,1,32'h4,32'h8C09_0004, 0,0,1,1,16'd1);
    add(0,0,8'h00, 0,0,32'h0,32'h0, 1,0,0,0,16'd2);
    add(0,1,8'h55, 0,0,32'h0,32'h0, 1,0,0,0,16'd2);
    // Zero-length header
    add(1,0,8'h00, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h00, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h00, 0,0,32'h0,32'h0, 1,0,0,0,16'd0);
    add(0,0,8'h00, 0,0,32'h0,32'h0, 1,0,0,0,16'd0);
    // Oversize header (257)
    add(1,0,8'h00, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h01, 1,0,32'h0,32'h0, 0,0,1,1,16'd0);
    add(0,1,8'h01, 0,0,32'h0,32'h0, 0,1,1,0,16'd0);
    add(0,1,8'h00, 0,0,32'h0,32'h0, 0,1,1,0,16'd0);

    // Reset state
    #2;
    check("rst byte_ready", 32'(rdy_a), 32'd0);
    check("rst MemWrite",   32'(mw_a),  32'd0);
    check("rst cpu_hold",   32'(hold_a), 32'd0);
    check("rst busy",       32'(busy_a), 32'd0);
    check("rst done",       32'(done_a), 32'd0);
    check("rst error",      32'(err_a),  32'd0);
    check("rst address",    addr_a, 32'h0);
    check("rst address_b",  addr_b, 32'h100);
    check("rst write_data", wd_a, 32'h0);
    check("rst word_count", 32'(wc_a), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      start      = tbl[i].st;
      byte_valid = tbl[i].vl;
      byte_data  = tbl[i].dat;
      @(posedge clk);
      #1;
      check($sformatf("v%0d byte_ready", i), 32'(rdy_a), 32'(tbl[i].rdy));
      check($sformatf("v%0d MemWrite", i),   32'(mw_a),  32'(tbl[i].mw));
      if (tbl[i].mw) begin
        check($sformatf("v%0d address", i),    addr_a, tbl[i].addr);
        check($sformatf("v%0d write_data", i), wd_a,   tbl[i].wd);
      end
      check($sformatf("v%0d done", i),       32'(done_a), 32'(tbl[i].dn));
      check($sformatf("v%0d error", i),      32'(err_a),  32'(tbl[i].er));
      check($sformatf("v%0d cpu_hold", i),   32'(hold_a), 32'(tbl[i].hd));
      check($sformatf("v%0d busy", i),       32'(busy_a), 32'(tbl[i].bz));
      check($sformatf("v%0d word_count", i), 32'(wc_a),   32'(tbl[i].wc));
    end
    start = 1'b0; byte_valid = 1'b0;

    // Source stalls: valid toggles, and 8C is held across WRITE
    wq_a.delete();
    pulse_start();
    put_byte(8'h00, 1); put_byte(8'h02, 1);
    put_byte(8'h20, 1); put_byte(8'h08, 1); put_byte(8'h00, 1);
    put_byte(8'h05, 0);
    put_byte(8'h8C, 1); put_byte(8'h09, 1); put_byte(8'h00, 1);
    put_byte(8'h04, 1);
    wait_done("stall done");
    check("stall nwrites", 32'(wq_a.size()), 32'd2);
    if (wq_a.size() >= 2) begin
      check("stall w0 addr", wq_a[0][63:32], 32'h0);
      check("stall w0 data", wq_a[0][31:0],  32'h2008_0005);
      check("stall w1 addr", wq_a[1][63:32], 32'h4);
      check("stall w1 data", wq_a[1][31:0],  32'h8C09_0004);
    end
    check("stall word_count", 32'(wc_a), 32'd2);

    // Reset after 2 of 4 data bytes
    wq_a.delete();
    pulse_start();
    put_byte(8'h00, 0); put_byte(8'h01, 0);
    put_byte(8'h20, 0); put_byte(8'h08, 0);
    #3;
    reset = 1'b1;
    #1;
    check("mrst byte_ready", 32'(rdy_a),  32'd0);
    check("mrst cpu_hold",   32'(hold_a), 32'd0);
    check("mrst busy",       32'(busy_a), 32'd0);
    check("mrst MemWrite",   32'(mw_a),   32'd0);
    check("mrst word_count", 32'(wc_a),   32'd0);
    check("mrst address",    addr_a, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check("mrst no write", 32'(wq_a.size()), 32'd0);
    pulse_start();
    put_byte(8'h00, 0); put_byte(8'h01, 0);
    put_byte(8'h11, 0); put_byte(8'h22, 0); put_byte(8'h33, 0);
    put_byte(8'h44, 0);
    wait_done("mrst reload done");
    check("mrst nwrites", 32'(wq_a.size()), 32'd1);
    if (wq_a.size() >= 1) begin
      check("mrst w0 addr", wq_a[0][63:32], 32'h0);
      check("mrst w0 data", wq_a[0][31:0],  32'h1122_3344);
    end

    // N == MAX_WORDS is accepted
    pulse_start();
    put_byte(8'h01, 0); put_byte(8'h00, 0);
    check("max busy",       32'(busy_a), 32'd1);
    check("max error",      32'(err_a),  32'd0);
    check("max byte_ready", 32'(rdy_a),  32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // start during DATA is ignored
    wq_a.delete();
    pulse_start();
    put_byte(8'h00, 0); put_byte(8'h02, 0);
    put_byte(8'h20, 0); put_byte(8'h08, 0);
    pulse_start();
    put_byte(8'h00, 0); put_byte(8'h05, 0);
    put_byte(8'h8C, 0); put_byte(8'h09, 0); put_byte(8'h00, 0);
    put_byte(8'h04, 0);
    wait_done("ign done");
    check("ign nwrites", 32'(wq_a.size()), 32'd2);
    if (wq_a.size() >= 2) begin
      check("ign w0 data", wq_a[0][31:0], 32'h2008_0005);
      check("ign w1 data", wq_a[1][31:0], 32'h8C09_0004);
    end

    // Restart from DONE; BASE_ADDR=0x100 instance writes to 0x100
    pulse_start();
    check("rs word_count", 32'(wc_a),   32'd0);
    check("rs done",       32'(done_a), 32'd0);
    check("rs busy",       32'(busy_a), 32'd1);
    mark = wq_b.size();
    put_byte(8'h00, 0); put_byte(8'h01, 0);
    put_byte(8'hAA, 0); put_byte(8'hBB, 0); put_byte(8'hCC, 0);
    put_byte(8'hDD, 0);
    wait_done("rs done end");
    check("rs b nwrites", 32'(wq_b.size() - mark), 32'd1);
    if (wq_b.size() > mark) begin
      check("rs b addr", wq_b[mark][63:32], 32'h100);
      check("rs b data", wq_b[mark][31:0],  32'hAABB_CCDD);
    end
    check("rs word_count end", 32'(wc_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
